// File: rtl/fp_subtractor_seq.sv
// Multi-cycle FP subtractor, diff = a - b, binary32 or binary16 by selector.
// Align, subtract, then normalise one bit per cycle; done pulses with diff.
module fp_subtractor_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        selector,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OP,
    NORM,
    DONE
  } state_t;

  state_t      state;
  logic        fmt;
  logic        sa;
  logic        sb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] ma;
  logic [23:0] mb;
  logic        sr;
  logic [7:0]  er;
  logic [24:0] ml;
  logic [24:0] ms;
  logic        eff_sub;

  // binary16 mantissas sit left-aligned: hidden bit at 23, 13 zero LSBs
  function automatic logic [32:0] unpack(
    input logic [31:0] w,
    input logic        f
  );
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    if (f) begin
      s = w[15];
      e = {3'b000, w[14:10]};
      m = {1'b1, w[9:0], 13'b0};
    end else begin
      s = w[31];
      e = w[30:23];
      m = {1'b1, w[22:0]};
    end
    if (e == 8'd0) m = '0;
    return {s, e, m};
  endfunction

  function automatic logic [31:0] pack(
    input logic        f,
    input logic        s,
    input logic [7:0]  e,
    input logic [22:0] m
  );
    if (f) return {16'b0, s, e[4:0], m[22:13]};
    return {s, e, m};
  endfunction

  logic [32:0] ua;
  logic [32:0] ub;

  assign ua = unpack(a, selector);
  assign ub = unpack(b, selector);

  logic        b_gt;
  logic [7:0]  e_l;
  logic [7:0]  e_s;
  logic [7:0]  sh;
  logic [23:0] m_l;
  logic [23:0] m_s;
  logic [24:0] m_sh;
  logic [24:0] m_mask;

  always_comb begin
    b_gt   = {eb, mb} > {ea, ma};
    e_l    = b_gt ? eb : ea;
    e_s    = b_gt ? ea : eb;
    m_l    = b_gt ? mb : ma;
    m_s    = b_gt ? ma : mb;
    sh     = e_l - e_s;
    m_mask = fmt ? 25'h1ffe000 : 25'h1ffffff;
    if (sh >= (fmt ? 8'd12 : 8'd25))
      m_sh = '0;
    else
      m_sh = ({1'b0, m_s} >> sh) & m_mask;
  end

  logic [24:0] m_res;
  logic [8:0]  e_inc;
  logic [7:0]  e_max;

  always_comb begin
    e_max = fmt ? 8'd31 : 8'd255;
    m_res = eff_sub ? (ml - ms) : (ml + ms);
    e_inc = {1'b0, er} + 9'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      fmt     <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      ea      <= '0;
      eb      <= '0;
      ma      <= '0;
      mb      <= '0;
      sr      <= 1'b0;
      er      <= '0;
      ml      <= '0;
      ms      <= '0;
      eff_sub <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            fmt   <= selector;
            sa    <= ua[32];
            ea    <= ua[31:24];
            ma    <= ua[23:0];
            sb    <= ~ub[32];
            eb    <= ub[31:24];
            mb    <= ub[23:0];
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sr      <= b_gt ? sb : sa;
          er      <= e_l;
          ml      <= {1'b0, m_l};
          ms      <= m_sh;
          eff_sub <= sa ^ sb;
          state   <= OP;
        end
        OP: begin
          if (m_res == '0) begin
            diff  <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else if (m_res[24]) begin
            if (e_inc >= {1'b0, e_max}) begin
              diff  <= pack(fmt, sr, e_max, 23'd0);
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ml    <= (m_res >> 1) & m_mask;
              er    <= e_inc[7:0];
              state <= NORM;
            end
          end else begin
            ml    <= m_res;
            state <= NORM;
          end
        end
        NORM: begin
          if (ml[23]) begin
            diff  <= pack(fmt, sr, er, ml[22:0]);
            done  <= 1'b1;
            state <= DONE;
          end else if (er <= 8'd1) begin
            diff  <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ml <= ml << 1;
            er <= er - 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Bench for fp_subtractor_seq: directed cases, control abuse, random ops
// against an integer-arithmetic reference model.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        selector = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] diff;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_subtractor_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .selector (selector),
    .busy     (busy),
    .done     (done),
    .diff     (diff)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] packf(input bit sel, input longint s,
                                        input longint e, input longint f);
    if (sel) return 32'((s << 15) | (e << 10) | f);
    return 32'((s << 31) | (e << 23) | f);
  endfunction

  // Reference: real-valued rules on integer mantissas of width M+1
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input bit sel, output logic [31:0] r,
                                output int lat);
    longint m_w, emax, one;
    longint sx, sy, ex, ey, mx, my;
    longint sl, el, ml, ms, d, m, e;
    int k;
    m_w  = sel ? 10 : 23;
    emax = sel ? 31 : 255;
    one  = longint'(1) << m_w;
    if (sel) begin
      sx = (x >> 15) & 1; ex = (x >> 10) & 31; mx = x & 32'h3ff;
      sy = ((y >> 15) & 1) ^ 1; ey = (y >> 10) & 31; my = y & 32'h3ff;
    end else begin
      sx = (x >> 31) & 1; ex = (x >> 23) & 255; mx = x & 32'h7fffff;
      sy = ((y >> 31) & 1) ^ 1; ey = (y >> 23) & 255; my = y & 32'h7fffff;
    end
    mx = (ex == 0) ? 0 : mx + one;
    my = (ey == 0) ? 0 : my + one;
    if (ey > ex || (ey == ex && my > mx)) begin
      sl = sy; el = ey; ml = my; ms = mx; d = ey - ex;
    end else begin
      sl = sx; el = ex; ml = mx; ms = my; d = ex - ey;
    end
    ms = (d >= m_w + 2) ? 0 : (ms >> d);
    m = (sx == sy) ? ml + ms : ml - ms;
    e = el;
    r = '0;
    lat = 3;
    if (m == 0) return;
    if (m >= 2 * one) begin
      m = m >> 1;
      e++;
      if (e >= emax) begin
        r = packf(sel, sl, emax, 0);
        return;
      end
    end
    k = 0;
    while (m < one) begin
      if (e == 1) begin
        r = '0;
        lat = 4 + k;
        return;
      end
      m = m << 1;
      e--;
      k++;
    end
    r = packf(sel, sl, e, m - one);
    lat = 4 + k;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] ia,
                        input logic [31:0] ib, input bit isel, input int inj,
                        input logic [31:0] exp_d, input int exp_lat);
    int n;
    bit got;
    bit busy_ok;
    @(negedge clk);
    a = ia;
    b = ib;
    selector = isel;
    start = 1'b1;
    n = 0;
    got = 0;
    busy_ok = 1;
    while (!got && n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        selector = 1'($urandom_range(0, 1));
      end
      if (inj != 0 && n == inj) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
      end
      if (inj != 0 && n == inj + 1) start = 1'b0;
      if (!busy) busy_ok = 0;
      if (done) got = 1;
    end
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " diff"}, diff, exp_d);
      chk({tag, " latency"}, n, exp_lat);
      chk({tag, " busy_held"}, 32'(busy_ok), 32'd1);
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " busy_clear"}, 32'(busy), 32'd0);
      chk({tag, " diff_hold"}, diff, exp_d);
    end
  endtask

  logic [31:0] ra, rb, rd;
  int          rl;
  bit          rsel;
  longint      emx, fw, xe, ye, xf, yf, xs, ys;
  bit          seen;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", diff, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("zero_shift", 32'h40400000, 32'h3f800000, 1'b0, 0, 32'h40000000, 4);
    run_op("carry", 32'h3fc00000, 32'hbfc00000, 1'b0, 0, 32'h40400000, 4);
    run_op("cancel", 32'h3f800000, 32'h3f800000, 1'b0, 0, 32'h00000000, 3);
    run_op("max_norm", 32'h3f800001, 32'h3f800000, 1'b0, 0, 32'h34000000, 27);
    run_op("half_neg", 32'h00003c00, 32'h00004000, 1'b1, 0, 32'h0000bc00, 5);
    run_op("start_in_norm", 32'h3f800001, 32'h3f800000, 1'b0, 8,
           32'h34000000, 27);

    @(negedge clk);
    a = 32'h3f800001;
    b = 32'h3f800000;
    selector = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst diff", diff, 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("midrst no_done", 32'(seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 32'h40400000, 32'h3f800000, 1'b0, 0, 32'h40000000, 4);

    for (int i = 0; i < 150; i++) begin
      rsel = 1'($urandom_range(0, 1));
      emx = rsel ? 30 : 254;
      fw = rsel ? 10 : 23;
      xe = $urandom_range(1, 32'(emx));
      case ($urandom_range(0, 3))
        0: ye = $urandom_range(1, 32'(emx));
        1: ye = xe;
        default: ye = xe + longint'($urandom_range(0, 4)) - 2;
      endcase
      if (ye < 1) ye = 1;
      if (ye > emx) ye = emx;
      if ($urandom_range(0, 15) == 0) xe = 0;
      xf = longint'($urandom) & ((longint'(1) << fw) - 1);
      if ($urandom_range(0, 2) == 0)
        yf = xf ^ (longint'($urandom) & 15);
      else
        yf = longint'($urandom) & ((longint'(1) << fw) - 1);
      xs = $urandom_range(0, 1);
      ys = $urandom_range(0, 1);
      if (rsel) begin
        ra = ($urandom & 32'hffff0000) | packf(1'b1, xs, xe, xf);
        rb = ($urandom & 32'hffff0000) | packf(1'b1, ys, ye, yf);
      end else begin
        ra = packf(1'b0, xs, xe, xf);
        rb = packf(1'b0, ys, ye, yf);
      end
      model(ra, rb, rsel, rd, rl);
      run_op($sformatf("rand%0d", i), ra, rb, rsel, 0, rd, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_subtractor_seq.md
Name: fp_subtractor_seq

Overview:
- Multi-cycle floating-point subtractor computing diff = a - b, the inverse operation of the team's combinational FP adder.
- Uses the same dual-format selector convention:
  - selector=0: IEEE-754 binary32 on the full 32-bit words.
  - selector=1: binary16 on bits [15:0], upper result bits zero.
- Operands are captured on a start handshake, then aligned, subtracted and normalised (one left shift per cycle) by an FSM.
- Sits in the datapath beside the adder; result is flagged by a done pulse.

Parameters:
- None; formats are fixed at binary32 (E=8, M=23) and binary16 (E=5, M=10).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  32  minuend (binary16 uses [15:0])
- b  input  32  subtrahend (binary16 uses [15:0])
- selector  input  1  0=binary32, 1=binary16; latched with operands
- busy  output  1  high from the cycle after start is accepted until DONE exits
- done  output  1  one-cycle pulse; diff valid
- diff  output  32  result; held until the next done

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, diff=0, all internal registers cleared.
- IDLE:
  - When start=1, latch a, b and selector, invert b's sign (a-b = a+(-b)), set busy=1, go to ALIGN.
  - start while busy is ignored; no queueing.
- Unpack rules:
  - Hidden bit is 1 unless exponent field=0, which is treated as zero (hidden bit 0; no denormals).
  - Inf/NaN inputs get no special treatment.
- ALIGN (1 cycle):
  - Order operands by magnitude: compare {exp,mant}; the larger becomes L, ties go to a.
  - Shift S mantissa right by (expL-expS) with a single barrel shift.
  - A shift >= M+2 yields 0.
  - Result sign = sign of L. Truncate; no guard/round bits.
- OP (1 cycle):
  - Equal signs: add mantissas (M+2 bits). On carry, shift right 1 and increment exponent.
  - Different signs: subtract L-S (never negative).
  - Zero result: diff=+0 (all zero), go directly to DONE.
  - Exponent overflow to all-ones: result = infinity (sign, exp all ones, mantissa 0), go to DONE.
  - Otherwise go to NORM.
- NORM (k+1 cycles):
  - Each cycle: if mantissa bit M is 1, go to DONE.
  - Else shift left 1 and decrement exponent.
  - If the exponent would reach 0, result=+0 (underflow flush) and go to DONE.
  - k = number of shifts, 0..M.
- DONE (1 cycle):
  - done=1; diff loads the packed result.
  - binary16 result is {16'b0, s, e[4:0], m[9:0]}.
  - Go to IDLE; busy=0 from the next cycle.
  - start can be accepted on the first IDLE cycle.
- Latency, counting the start-sampling edge as edge 1:
  - Normal path: done is high after edge 4+k.
  - Zero or overflow path: done is high after edge 3.
- Inputs a, b and selector may change freely after acceptance.
- Reset mid-operation aborts the operation; no done is issued.

Test Plan:
- binary32 zero-shift case: a=0x40400000 (3.0), b=0x3F800000 (1.0) -> diff=0x40000000, k=0, done after edge 4.
- Effective add with carry: a=0x3FC00000 (1.5), b=0xBFC00000 (-1.5) -> diff=0x40400000 (3.0).
- Exact cancellation: a=b=0x3F800000 -> diff=0x00000000, done after edge 3.
- Maximum normalisation: a=0x3F800001, b=0x3F800000 -> diff=0x34000000, k=23, done after edge 27.
- binary16 with negative result: selector=1, a=0x00003C00 (1.0), b=0x00004000 (2.0) -> diff=0x0000BC00 (-1.0), k=1.
- Control handling:
  - Pulse start during NORM with other operands -> ignored; original result produced.
  - Drop rst_n during NORM -> busy/done/diff=0 immediately.
  - New start after release -> correct result.
